// File: rtl/pixel_writer.sv
// Buffers the rasterizer pixel stream in a small FIFO and writes each visible pixel to a linear framebuffer over a req/ack port.
// Optional PIXEL_WRITER_STATS_EN adds saturating drop_count / clip_count outputs.
module pixel_writer #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int DEPTH        = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pixel_valid,
  input  logic [WIDTH_BITS-1:0]               pixel_x,
  input  logic [HEIGHT_BITS-1:0]              pixel_y,
  input  logic [CHANNEL_BITS-1:0]             pixel_r,
  input  logic [CHANNEL_BITS-1:0]             pixel_g,
  input  logic [CHANNEL_BITS-1:0]             pixel_b,
  output logic                                mem_req,
  output logic [WIDTH_BITS+HEIGHT_BITS-1:0]   mem_addr,
  output logic [3*CHANNEL_BITS-1:0]           mem_data,
  input  logic                                mem_ack,
  output logic                                busy,
  output logic                                overflow
`ifdef PIXEL_WRITER_STATS_EN
  ,
  output logic [15:0]                         drop_count,
  output logic [15:0]                         clip_count
`endif
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int ADDR_W = WIDTH_BITS + HEIGHT_BITS;
  localparam int DATA_W = 3 * CHANNEL_BITS;
  localparam logic [31:0] SCREEN_W_L = SCREEN_W;
  localparam logic [31:0] SCREEN_H_L = SCREEN_H;

  typedef struct packed {
    logic [WIDTH_BITS-1:0]  x;
    logic [HEIGHT_BITS-1:0] y;
    logic [DATA_W-1:0]      rgb;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE
  } state_t;

  state_t             state_q, state_d;
  pixel_t             fifo_q [DEPTH];
  pixel_t             fifo_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  pixel_t             hold_q, hold_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               overflow_q, overflow_d;

  logic full;
  logic push;
  logic drop;
  logic pop;
  logic in_bounds;
  logic clip;

  // A push while full is lost even if the FSM pops on the same edge.
  always_comb begin
    full = (count_q == CNT_W'(DEPTH));
    push = pixel_valid && !full;
    drop = pixel_valid && full;
    pop  = (state_q == IDLE) && (count_q != '0);
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {pixel_x, pixel_y, pixel_r, pixel_g, pixel_b};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    in_bounds = (32'(hold_q.x) < SCREEN_W_L) && (32'(hold_q.y) < SCREEN_H_L);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    data_d  = data_q;
    clip    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          hold_d  = fifo_q[rd_ptr_q];
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_bounds) begin
          addr_d  = ADDR_W'(hold_q.y) * ADDR_W'(SCREEN_W) + ADDR_W'(hold_q.x);
          data_d  = hold_q.rgb;
          state_d = WRITE;
        end else begin
          clip    = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q || drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read behind the pointers.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign mem_req  = (state_q == WRITE);
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign busy     = (count_q != '0) || (state_q != IDLE);
  assign overflow = overflow_q;

`ifdef PIXEL_WRITER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    clip_cnt_d = clip_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
    if (clip && (clip_cnt_q != '1)) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      clip_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
  assign clip_count = clip_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: directed timing/boundary cases plus randomized bursts against a queue-based write model.
module tb_pixel_writer;

  localparam int SW    = 640;
  localparam int SH    = 480;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic [7:0]  pixel_r, pixel_g, pixel_b;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic [23:0] mem_data;
  logic        mem_ack;
  logic        busy;
  logic        overflow;
`ifdef PIXEL_WRITER_STATS_EN
  logic [15:0] drop_count;
  logic [15:0] clip_count;
`endif

  always #5 clk = ~clk;

  pixel_writer #(
    .WIDTH_BITS  (10),
    .HEIGHT_BITS (9),
    .CHANNEL_BITS(8),
    .SCREEN_W    (SW),
    .SCREEN_H    (SH),
    .DEPTH       (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_valid(pixel_valid),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_r    (pixel_r),
    .pixel_g    (pixel_g),
    .pixel_b    (pixel_b),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .overflow   (overflow)
`ifdef PIXEL_WRITER_STATS_EN
    ,
    .drop_count (drop_count),
    .clip_count (clip_count)
`endif
  );

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_wr  = 0;
  bit  ack_rand = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: every accepted, visible pixel becomes one write, in arrival order.
  task automatic send(input int x, input int y, input logic [23:0] rgb, input bit accept);
    pixel_valid = 1'b1;
    pixel_x     = 10'(x);
    pixel_y     = 9'(y);
    {pixel_r, pixel_g, pixel_b} = rgb;
    if (accept && x < SW && y < SH) begin
      exp_q.push_back('{addr: 19'(y * SW + x), data: rgb});
    end
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [23:0] rand_rgb();
    return 24'($urandom);
  endfunction

  // Handshake observed mid-cycle; completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        check_eq("wr_unexpected", 32'(mem_req), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(exp_e.addr));
        check_eq("wr_data", 32'(mem_data), 32'(exp_e.data));
      end
      n_wr++;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (ack_rand) mem_ack = ($urandom_range(0, 99) < 60);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n0;
    logic [23:0] rgb;
    rst = 1'b1; pixel_valid = 1'b0; pixel_x = '0; pixel_y = '0;
    pixel_r = '0; pixel_g = '0; pixel_b = '0; mem_ack = 1'b0;

    // Reset
    repeat (2) tick();
    rst = 1'b0;
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_data", 32'(mem_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
`ifdef PIXEL_WRITER_STATS_EN
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    check_eq("rst_clip", 32'(clip_count), 32'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_req", 32'(mem_req), 32'd0);
    end

    // Single pixel, ack tied high: request appears after edge k+2
    mem_ack = 1'b1;
    send(100, 25, 24'hFFFFFF, 1'b1);
    check_eq("single_req_k", 32'(mem_req), 32'd0);
    check_eq("single_busy", 32'(busy), 32'd1);
    tick();
    check_eq("single_req_k1", 32'(mem_req), 32'd0);
    tick();
    check_eq("single_req_k2", 32'(mem_req), 32'd1);
    check_eq("single_addr", 32'(mem_addr), 32'd16100);
    check_eq("single_data", 32'(mem_data), 32'hFFFFFF);
    tick();
    check_eq("single_req_k3", 32'(mem_req), 32'd0);
    check_eq("single_busy_end", 32'(busy), 32'd0);
    check_eq("single_nwr", 32'(n_wr), 32'd1);

    // Clipping
    n0 = n_wr;
    send(700, 10, rand_rgb(), 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("clip_req", 32'(mem_req), 32'd0);
    end
    check_eq("clip_busy", 32'(busy), 32'd0);
    check_eq("clip_nwr", 32'(n_wr), 32'(n0));
`ifdef PIXEL_WRITER_STATS_EN
    check_eq("clip_count", 32'(clip_count), 32'd1);
`endif

    // Stall: outputs held while ack is low
    mem_ack = 1'b0;
    n0  = n_wr;
    rgb = rand_rgb();
    send(3, 7, rgb, 1'b1);
    tick();
    tick();
    check_eq("stall_req0", 32'(mem_req), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_req", 32'(mem_req), 32'd1);
      check_eq("stall_addr", 32'(mem_addr), 32'(7 * SW + 3));
      check_eq("stall_data", 32'(mem_data), 32'(rgb));
    end
    mem_ack = 1'b1;
    tick();
    check_eq("stall_req_end", 32'(mem_req), 32'd0);
    check_eq("stall_nwr", 32'(n_wr), 32'(n0 + 1));
    check_eq("stall_busy", 32'(busy), 32'd0);

    // Bounds edges: last visible pixel, one past each edge, origin
    send(SW - 1, SH - 1, rand_rgb(), 1'b1);
    send(SW, 0, rand_rgb(), 1'b1);
    send(0, SH, rand_rgb(), 1'b1);
    send(0, 0, rand_rgb(), 1'b1);
    wait_idle(50);
    check_eq("bounds_pending", 32'(exp_q.size()), 32'd0);
    check_eq("bounds_ovf", 32'(overflow), 32'd0);

    // Overflow: 1 in flight + DEPTH buffered survive, the rest are dropped
    mem_ack = 1'b0;
    n0 = n_wr;
    for (int i = 0; i < 12; i++) begin
      send(i, 0, rand_rgb(), i < DEPTH + 1);
    end
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_req", 32'(mem_req), 32'd1);
`ifdef PIXEL_WRITER_STATS_EN
    check_eq("ovf_drop", 32'(drop_count), 32'd3);
`endif
    mem_ack = 1'b1;
    wait_idle(100);
    check_eq("ovf_pending", 32'(exp_q.size()), 32'd0);
    check_eq("ovf_nwr", 32'(n_wr), 32'(n0 + DEPTH + 1));
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Reset during WRITE with 4 pixels buffered
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(20 + i, 5, rand_rgb(), 1'b1);
    end
    check_eq("rmw_req_pre", 32'(mem_req), 32'd1);
    check_eq("rmw_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_eq("rmw_req", 32'(mem_req), 32'd0);
    check_eq("rmw_busy", 32'(busy), 32'd0);
    check_eq("rmw_ovf", 32'(overflow), 32'd0);
    check_eq("rmw_addr", 32'(mem_addr), 32'd0);
    check_eq("rmw_data", 32'(mem_data), 32'd0);
    n0 = n_wr;
    mem_ack = 1'b1;
    repeat (20) tick();
    check_eq("rmw_nwr", 32'(n_wr), 32'(n0));
    check_eq("rmw_busy_end", 32'(busy), 32'd0);

    // Randomized bursts no larger than the stalled capacity, random ack
    ack_rand = 1'b1;
    for (int b = 0; b < 30; b++) begin
      int len;
      len = $urandom_range(1, DEPTH + 1);
      for (int j = 0; j < len; j++) begin
        int x, y;
        while ($urandom_range(0, 99) < 30) tick();
        x = ($urandom_range(0, 99) < 15) ? $urandom_range(SW, 1023) : $urandom_range(0, SW - 1);
        y = ($urandom_range(0, 99) < 15) ? $urandom_range(SH, 511) : $urandom_range(0, SH - 1);
        send(x, y, rand_rgb(), 1'b1);
      end
      wait_idle(300);
      check_eq("rand_pending", 32'(exp_q.size()), 32'd0);
    end
    ack_rand = 1'b0;
    check_eq("rand_ovf", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
